// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch front end
package fetch_pkg;
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: imem request/response, redirect and decode-side handshake bundle of the fetch unit
interface fetch_if #(parameter int XLEN = 32);
  logic imem_req_valid;
  logic imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic instr_valid;
  logic instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  modport master(
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );
  modport slave(
    input imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction buffer with registered head that holds its last value while empty
module fetch_fifo #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic flush,
  input logic push,
  input logic pop,
  input logic [XLEN-1:0] push_instr,
  input logic [XLEN-1:0] push_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic [XLEN-1:0] head_instr,
  output logic [XLEN-1:0] head_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [XLEN-1:0] mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_pop, do_push;
  logic [CW-1:0] kept;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  assign kept = count - CW'(do_pop);
  always_ff @(posedge clk)
    if (!flush && do_push) begin
      mem_instr[wr_ptr] <= push_instr;
      mem_pc[wr_ptr] <= push_pc;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      head_instr <= '0;
      head_pc <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= kept + CW'(do_push);
      if (kept != '0) begin
        head_instr <= mem_instr[rd_ptr + PW'(do_pop)];
        head_pc <= mem_pc[rd_ptr + PW'(do_pop)];
      end else if (do_push) begin
        head_instr <= push_instr;
        head_pc <= push_pc;
      end
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, credit-limited imem requests, redirect flush; FETCH_PERF_EN adds perf counters
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  fetch_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;
  logic [1:0] state;
  logic [XLEN-1:0] pc, rsp_pc;
  logic [CW-1:0] inflight, drop_cnt, drop_nxt, fifo_count, remain;
  logic rsp_ret, req_fire, push, pop;
  assign rsp_ret = bus.imem_rsp_valid && inflight != '0;
  assign remain = inflight - CW'(rsp_ret);
  assign drop_nxt = drop_cnt - CW'(state == ST_FLUSH && rsp_ret);
  assign bus.imem_req_valid = state == ST_RUN && !bus.redirect_valid &&
                              SW'(fifo_count) + SW'(inflight) < SW'(FIFO_DEPTH);
  assign bus.imem_req_addr = pc;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_pc = pc - (XLEN'(inflight) << 2);
  assign push = state == ST_RUN && rsp_ret && !bus.redirect_valid;
  assign pop = bus.instr_valid && bus.instr_ready;
  assign bus.instr_valid = fifo_count != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BOOT;
      pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else if (bus.redirect_valid) begin
      pc <= bus.redirect_pc & ~XLEN'(3);
      inflight <= remain;
      drop_cnt <= remain;
      state <= remain != '0 ? ST_FLUSH : ST_RUN;
    end else begin
      inflight <= remain + CW'(req_fire);
      drop_cnt <= drop_nxt;
      if (req_fire) pc <= pc + XLEN'(4);
      state <= (state == ST_BOOT || (state == ST_FLUSH && drop_nxt == '0)) ? ST_RUN : state;
    end
  end
  fetch_fifo #(.XLEN(XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(bus.redirect_valid),
    .push(push),
    .pop(pop),
    .push_instr(bus.imem_rsp_data),
    .push_pc(rsp_pc),
    .count(fifo_count),
    .head_instr(bus.instr),
    .head_pc(bus.instr_pc)
  );
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall <= '0;
    end else begin
      if (push && ~&perf_fetched) perf_fetched <= perf_fetched + 32'd1;
      if (state == ST_RUN && !bus.instr_valid && ~&perf_stall) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench with an in-order 1-cycle imem responder model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  logic rdy, rsp_en, iready, redir;
  logic [31:0] redir_pc;
  logic s_rv, s_iv, s_fire, s_pop;
  logic [31:0] s_addr, s_instr, s_ipc;
  logic [31:0] pend [$];
  int checks = 0;
  int errors = 0;
  fetch_if #(.XLEN(32)) bus();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, s_pf, s_ps;
`endif
  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  task automatic cycle();
    bus.imem_req_ready = rdy;
    bus.instr_ready = iready;
    bus.redirect_valid = redir;
    bus.redirect_pc = redir_pc;
    bus.imem_rsp_valid = rsp_en && pend.size() > 0;
    bus.imem_rsp_data = pend.size() > 0 ? f(pend[0]) : 32'h0;
    #1;
    s_rv = bus.imem_req_valid;
    s_addr = bus.imem_req_addr;
    s_iv = bus.instr_valid;
    s_instr = bus.instr;
    s_ipc = bus.instr_pc;
    s_fire = s_rv && rdy;
    s_pop = s_iv && iready;
`ifdef FETCH_PERF_EN
    s_pf = perf_fetched;
    s_ps = perf_stall;
`endif
    @(posedge clk);
    if (bus.imem_rsp_valid) void'(pend.pop_front());
    if (s_fire) pend.push_back(s_addr);
    if (rst) pend.delete();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1; rdy = 0; rsp_en = 0; iready = 0; redir = 0; redir_pc = 0;
    cycle();
    rst = 0;
    cycle();
  endtask
  task automatic seek(output logic got_f, output logic [31:0] f_addr, output logic got_p,
                      output logic [31:0] p_pc, output logic [31:0] p_instr);
    got_f = 0; got_p = 0; f_addr = 0; p_pc = 0; p_instr = 0;
    rdy = 1; rsp_en = 1; iready = 1; redir = 0;
    for (int i = 0; i < 10 && !got_p; i++) begin
      cycle();
      if (s_fire && !got_f) begin got_f = 1; f_addr = s_addr; end
      if (s_pop) begin got_p = 1; p_pc = s_ipc; p_instr = s_instr; end
    end
  endtask
  task automatic test_reset();
    rst = 1; rdy = 0; rsp_en = 0; iready = 0; redir = 0; redir_pc = 0;
    cycle();
    cycle();
    checks++; if (s_rv !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", s_rv); end
    checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h want 0", s_addr); end
    checks++; if (s_iv !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", s_iv); end
    checks++; if (s_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", s_instr); end
    checks++; if (s_ipc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", s_ipc); end
    rst = 0;
    cycle();
    checks++; if (s_rv !== 1'b0) begin errors++; $display("FAIL boot_idle: got %b want 0", s_rv); end
    cycle();
    checks++; if (s_rv !== 1'b1 || s_addr !== 32'h0) begin errors++; $display("FAIL run_first_req: got %b/%h want 1/0", s_rv, s_addr); end
  endtask
  task automatic test_stream();
    logic [31:0] exp_pc;
    int pops;
    do_reset();
    rdy = 1; rsp_en = 1; iready = 1; exp_pc = 0; pops = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++; if (s_fire !== 1'b1 || s_addr !== 32'(i * 4)) begin errors++; $display("FAIL stream_addr[%0d]: got %b/%h want 1/%h", i, s_fire, s_addr, i * 4); end
      if (s_pop) begin
        checks++; if (s_ipc !== exp_pc || s_instr !== f(exp_pc)) begin errors++; $display("FAIL stream_pop: got %h/%h want %h/%h", s_ipc, s_instr, exp_pc, f(exp_pc)); end
        exp_pc += 4;
        pops++;
      end
    end
    checks++; if (pops !== 18) begin errors++; $display("FAIL stream_rate: got %0d pops want 18", pops); end
  endtask
  task automatic test_backpressure();
    int fires, pops;
    logic got_fire;
    do_reset();
    rdy = 1; rsp_en = 1; iready = 0; fires = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_fire) begin
        checks++; if (s_addr !== 32'(fires * 4)) begin errors++; $display("FAIL bp_addr: got %h want %h", s_addr, fires * 4); end
        fires++;
      end
    end
    checks++; if (fires !== 4) begin errors++; $display("FAIL bp_req_count: got %0d want 4", fires); end
    checks++; if (s_rv !== 1'b0 || s_iv !== 1'b1 || s_ipc !== 32'h0) begin errors++; $display("FAIL bp_full: got rv=%b iv=%b pc=%h want 0/1/0", s_rv, s_iv, s_ipc); end
    iready = 1; pops = 0; got_fire = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (s_pop && pops < 4) begin
        checks++; if (s_ipc !== 32'(pops * 4) || s_instr !== f(32'(pops * 4))) begin errors++; $display("FAIL bp_pop[%0d]: got %h/%h want %h", pops, s_ipc, s_instr, pops * 4); end
        pops++;
      end
      if (s_fire && !got_fire) begin
        got_fire = 1;
        checks++; if (s_addr !== 32'h10) begin errors++; $display("FAIL bp_resume: got %h want 00000010", s_addr); end
      end
    end
    checks++; if (pops !== 4 || got_fire !== 1'b1) begin errors++; $display("FAIL bp_drain: got pops=%0d fire=%b want 4/1", pops, got_fire); end
  endtask
  task automatic test_redirect();
    logic gf, gp;
    logic [31:0] fa, pp, pi;
    do_reset();
    rdy = 1; rsp_en = 0; iready = 1;
    cycle();
    cycle();
    redir = 1; redir_pc = 32'h103;
    cycle();
    checks++; if (s_rv !== 1'b0) begin errors++; $display("FAIL redir_req_blocked: got %b want 0", s_rv); end
    redir = 0; rsp_en = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++; if (s_rv !== 1'b0 || s_iv !== 1'b0) begin errors++; $display("FAIL flush_drop[%0d]: got rv=%b iv=%b want 0/0", i, s_rv, s_iv); end
    end
    seek(gf, fa, gp, pp, pi);
    checks++; if (gf !== 1'b1 || fa !== 32'h100) begin errors++; $display("FAIL redir_addr: got %b/%h want 1/00000100", gf, fa); end
    checks++; if (gp !== 1'b1 || pp !== 32'h100 || pi !== f(32'h100)) begin errors++; $display("FAIL redir_first_pc: got %b/%h/%h want 1/00000100/%h", gp, pp, pi, f(32'h100)); end
  endtask
  task automatic test_redirect_rsp();
    logic gf, gp;
    logic [31:0] fa, pp, pi;
    do_reset();
    rdy = 1; rsp_en = 0; iready = 1;
    cycle();
    rsp_en = 1; redir = 1; redir_pc = 32'h200;
    cycle();
    redir = 0;
    cycle();
    checks++; if (s_iv !== 1'b0) begin errors++; $display("FAIL redir_rsp_discard: got iv=%b want 0", s_iv); end
    checks++; if (s_rv !== 1'b1 || s_addr !== 32'h200) begin errors++; $display("FAIL redir_rsp_run: got %b/%h want 1/00000200", s_rv, s_addr); end
    seek(gf, fa, gp, pp, pi);
    checks++; if (gp !== 1'b1 || pp !== 32'h200 || pi !== f(32'h200)) begin errors++; $display("FAIL redir_rsp_pc: got %b/%h/%h want 1/00000200/%h", gp, pp, pi, f(32'h200)); end
  endtask
  task automatic test_stall_redirect();
    logic gf, gp;
    logic [31:0] fa, pp, pi;
    do_reset();
    rdy = 0; rsp_en = 0; iready = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (s_rv !== 1'b1 || s_addr !== 32'h0) begin errors++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/0", i, s_rv, s_addr); end
    end
    rdy = 1;
    cycle();
    checks++; if (s_fire !== 1'b1 || s_addr !== 32'h0) begin errors++; $display("FAIL stall_release0: got %b/%h want 1/0", s_fire, s_addr); end
    cycle();
    checks++; if (s_fire !== 1'b1 || s_addr !== 32'h4) begin errors++; $display("FAIL stall_release1: got %b/%h want 1/4", s_fire, s_addr); end
    redir = 1; redir_pc = 32'h300;
    cycle();
    redir_pc = 32'h400; rsp_en = 1;
    cycle();
    redir = 0;
    cycle();
    checks++; if (s_rv !== 1'b0) begin errors++; $display("FAIL flush_twice: got %b want 0", s_rv); end
    seek(gf, fa, gp, pp, pi);
    checks++; if (gf !== 1'b1 || fa !== 32'h400) begin errors++; $display("FAIL latest_redir_addr: got %b/%h want 1/00000400", gf, fa); end
    checks++; if (gp !== 1'b1 || pp !== 32'h400 || pi !== f(32'h400)) begin errors++; $display("FAIL latest_redir_pc: got %b/%h want 1/00000400", gp, pp); end
  endtask
`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int fires, pops;
    logic [31:0] snap;
    do_reset();
    rsp_en = 1; iready = 1; fires = 0; pops = 0; snap = 0;
    for (int i = 0; i < 14; i++) begin
      rdy = fires < 8;
      cycle();
      if (s_fire) fires++;
      if (s_pop) pops++;
      if (i == 9) begin
        snap = s_ps;
        checks++; if (s_ps !== 32'd2 || s_pf !== 32'd8) begin errors++; $display("FAIL perf_mid: got %0d/%0d want 8/2", s_pf, s_ps); end
      end
    end
    checks++; if (pops !== 8) begin errors++; $display("FAIL perf_pops: got %0d want 8", pops); end
    checks++; if (s_pf !== 32'd8) begin errors++; $display("FAIL perf_fetched: got %0d want 8", s_pf); end
    checks++; if (s_ps - snap !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d want 3", s_ps - snap); end
  endtask
`endif
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_rsp();
    test_stall_redirect();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
